pipe_hazard_ctrl: RTL

Pipeline sequencer for the 5-stage RV32 core. It sits beside the main decoder and drives the stall, flush and hold enables of the PC and the IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, flushes on taken branch/jal, and freezes the pipe while data memory is busy. It also generates ALU operand forwarding selects and keeps stall/flush performance counters.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fwd_unit.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline control: sequencer states,
// forwarding select encodings and the opcodes the main decoder also uses.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding selects for both EX source registers.
// The younger result in MEM wins over WB; x0 is never forwarded.
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_wr,
        input logic [4:0] w_rd,
        input logic       w_wr
    );
        if (m_wr && (m_rd != 5'd0) && (m_rd == rs))
            return FWD_MEM;
        else if (w_wr && (w_rd != 5'd0) && (w_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stall/flush/hold enables,
// data-memory wait handling with timeout, forwarding and perf counters.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       set_timeout;
    logic       stall_inc, flush_inc;
    logic       load_use;
    logic       pc_w, ifid_w, ifid_fl, bubble, hold;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        set_timeout = 1'b0;
        flush_inc   = 1'b0;
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        ifid_fl     = 1'b0;
        bubble      = 1'b0;
        hold        = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_access && !dmem_ready) begin
                    pc_w      = 1'b0;
                    ifid_w    = 1'b0;
                    hold      = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = 8'd1;
                end else if (branch_taken) begin
                    // ID instruction is discarded, so any load-use hazard is moot
                    ifid_fl   = 1'b1;
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = 8'd0;
                end else begin
                    pc_w     = 1'b0;
                    ifid_w   = 1'b0;
                    hold     = 1'b1;
                    wait_nxt = wait_cnt + 8'd1;
                    if (wait_nxt == WAIT_LIMIT) begin
                        state_nxt   = ST_ERROR;
                        set_timeout = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                hold   = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase

        stall_inc = !pc_w && (state != ST_ERROR);
    end

    // Reset overrides every enable so the pipe loads NOPs while held
    always_comb begin
        pc_write     = pc_w;
        if_id_write  = ifid_w;
        if_id_flush  = ifid_fl;
        id_ex_bubble = bubble;
        ex_mem_hold  = hold;
        fwd_a        = fwd_a_raw;
        fwd_b        = fwd_b_raw;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_hold  = 1'b0;
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (set_timeout)
                mem_timeout <= 1'b1;
            if (stall_inc)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
